// File: rtl/sfp_shadow_bank.sv
// Multi-channel dual-port shadow register bank for SFP modules: the host (s1) and the
// EEPROM poller (s2) share one bank per channel; an init sweep clears the bank after reset or sw_clear.
module sfp_shadow_bank #(
  parameter int                    NUM_CH     = 2,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 64,
  parameter int                    BE_WIDTH   = DATA_WIDTH / 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sw_clear,
  output logic                           init_done,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   s1_address,
  input  logic [NUM_CH-1:0]              s1_read,
  input  logic [NUM_CH-1:0]              s1_write,
  input  logic [NUM_CH*BE_WIDTH-1:0]     s1_byteenable,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   s1_writedata,
  output logic [NUM_CH-1:0]              s1_waitrequest,
  output logic [NUM_CH*DATA_WIDTH-1:0]   s1_readdata,
  output logic [NUM_CH-1:0]              s1_readdatavalid,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   s2_address,
  input  logic [NUM_CH-1:0]              s2_read,
  input  logic [NUM_CH-1:0]              s2_write,
  input  logic [NUM_CH*BE_WIDTH-1:0]     s2_byteenable,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   s2_writedata,
  output logic [NUM_CH-1:0]              s2_waitrequest,
  output logic [NUM_CH*DATA_WIDTH-1:0]   s2_readdata,
  output logic [NUM_CH-1:0]              s2_readdatavalid,
  output logic [NUM_CH-1:0]              dirty,
  input  logic [NUM_CH-1:0]              dirty_clr
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   ptr, ptr_nxt;
  logic                    ready;
  logic                    clear_start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    unique case (state)
      ST_INIT: begin
        ptr_nxt = ptr + 1'b1;
        if (ptr == '1) state_nxt = ST_READY;
      end
      ST_READY: begin
        if (sw_clear) begin
          state_nxt = ST_INIT;
          ptr_nxt   = '0;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  assign ready          = (state == ST_READY);
  assign clear_start    = ready & sw_clear;
  assign init_done      = ready;
  assign s1_waitrequest = {NUM_CH{~ready}};
  assign s2_waitrequest = {NUM_CH{~ready}};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [ADDR_WIDTH-1:0] a1, a2;
    logic [BE_WIDTH-1:0]   be1, be2;
    logic [DATA_WIDTH-1:0] wd1, wd2;
    logic                  wr1, wr2, rd1, rd2;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata2_q;
    logic                  rvalid1_q, rvalid2_q, dirty_q;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign a1  = s1_address[c*ADDR_WIDTH +: ADDR_WIDTH];
    assign a2  = s2_address[c*ADDR_WIDTH +: ADDR_WIDTH];
    assign be1 = s1_byteenable[c*BE_WIDTH +: BE_WIDTH];
    assign be2 = s2_byteenable[c*BE_WIDTH +: BE_WIDTH];
    assign wd1 = s1_writedata[c*DATA_WIDTH +: DATA_WIDTH];
    assign wd2 = s2_writedata[c*DATA_WIDTH +: DATA_WIDTH];
    assign wr1 = ready & s1_write[c];
    assign wr2 = ready & s2_write[c];
    assign rd1 = ready & s1_read[c];
    assign rd2 = ready & s2_read[c];

    // NOTE: the storage array has no reset; the init sweep is what clears it.
    // s2 lanes are assigned after s1 lanes, so s2 wins any byte both ports enable.
    always_ff @(posedge clk) begin
      if (!ready) begin
        mem[ptr] <= INIT_VALUE;
      end else begin
        for (int b = 0; b < BE_WIDTH; b++) begin
          if (wr1 && be1[b]) mem[a1][b*8 +: 8] <= wd1[b*8 +: 8];
        end
        for (int b = 0; b < BE_WIDTH; b++) begin
          if (wr2 && be2[b]) mem[a2][b*8 +: 8] <= wd2[b*8 +: 8];
        end
      end
    end

    // NOTE: non-blocking assignment means reads sample the word before any same-cycle write.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rdata1_q  <= '0;
        rdata2_q  <= '0;
        rvalid1_q <= 1'b0;
        rvalid2_q <= 1'b0;
      end else begin
        rvalid1_q <= rd1;
        rvalid2_q <= rd2;
        if (rd1) rdata1_q <= mem[a1];
        if (rd2) rdata2_q <= mem[a2];
      end
    end

    // A restarted sweep wipes the bank, so dirty restarts from clean; a new s2 write beats a clear.
    always_ff @(posedge clk or posedge reset) begin
      if (reset)             dirty_q <= 1'b0;
      else if (clear_start)  dirty_q <= 1'b0;
      else if (wr2)          dirty_q <= 1'b1;
      else if (dirty_clr[c]) dirty_q <= 1'b0;
    end

    assign s1_readdata[c*DATA_WIDTH +: DATA_WIDTH] = rdata1_q;
    assign s2_readdata[c*DATA_WIDTH +: DATA_WIDTH] = rdata2_q;
    assign s1_readdatavalid[c]                     = rvalid1_q;
    assign s2_readdatavalid[c]                     = rvalid2_q;
    assign dirty[c]                                = dirty_q;
  end

endmodule
